// File: rtl/regfile_scoreboard_if.sv
// Register scoreboard bus: pipeline control, issue/commit ports, queries.
// master drives requests, slave (the scoreboard) returns query results.
interface regfile_scoreboard_if #(
    parameter int TAG_W = 4
);
    logic             rdy_in;
    logic             flush_pipline;
    logic             issue_valid;
    logic [4:0]       issue_rd;
    logic [TAG_W-1:0] issue_tag;
    logic             commit_valid;
    logic [4:0]       commit_rd;
    logic [TAG_W-1:0] commit_tag;
    logic [4:0]       rs1_reg_id;
    logic [4:0]       rs2_reg_id;
    logic             rs1_busy;
    logic             rs2_busy;
    logic [TAG_W-1:0] rs1_tag;
    logic [TAG_W-1:0] rs2_tag;
    logic [5:0]       busy_count;

    modport master (
        output rdy_in, flush_pipline,
        output issue_valid, issue_rd, issue_tag,
        output commit_valid, commit_rd, commit_tag,
        output rs1_reg_id, rs2_reg_id,
        input  rs1_busy, rs2_busy, rs1_tag, rs2_tag,
        input  busy_count
    );

    modport slave (
        input  rdy_in, flush_pipline,
        input  issue_valid, issue_rd, issue_tag,
        input  commit_valid, commit_rd, commit_tag,
        input  rs1_reg_id, rs2_reg_id,
        output rs1_busy, rs2_busy, rs1_tag, rs2_tag,
        output busy_count
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register scoreboard: per-register busy bit and ROB tag of the pending
// producer for x1..x31, with a registered count of busy registers.
module regfile_scoreboard #(
    parameter int TAG_W = 4
) (
    input  logic                clk_in,
    input  logic                rst_in,
    regfile_scoreboard_if.slave bus
);

    logic [31:1]      busy_q;
    logic [TAG_W-1:0] tag_q [1:31];
    logic [5:0]       count_q;

    logic [31:1]      iss_hit;
    logic [31:1]      clr_hit;
    logic             cnt_inc;
    logic             cnt_dec;
    logic [5:0]       count_d;

    logic [31:0]      busy_v;
    logic [TAG_W-1:0] tag_v [0:31];

    // Decode which register the issue claims and which one a commit frees.
    always_comb begin
        iss_hit = '0;
        clr_hit = '0;
        for (int r = 1; r < 32; r++) begin
            iss_hit[r] = bus.issue_valid
                      && (bus.issue_rd == 5'(r));
            clr_hit[r] = bus.commit_valid
                      && (bus.commit_rd == 5'(r))
                      && busy_q[r]
                      && (tag_q[r] == bus.commit_tag);
        end
    end

    // Count delta: a claim on an idle register adds one; a matched commit
    // removes one unless the same register is reclaimed this cycle.
    always_comb begin
        cnt_inc = |(iss_hit & ~busy_q);
        cnt_dec = |(clr_hit & ~iss_hit);
        count_d = count_q
                + {5'd0, cnt_inc}
                - {5'd0, cnt_dec};
    end

    // Busy bits and tags; issue wins over commit on the same register.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy_q <= '0;
            for (int r = 1; r < 32; r++) begin
                tag_q[r] <= '0;
            end
        end else if (bus.rdy_in) begin
            if (bus.flush_pipline) begin
                busy_q <= '0;
                for (int r = 1; r < 32; r++) begin
                    tag_q[r] <= '0;
                end
            end else begin
                for (int r = 1; r < 32; r++) begin
                    if (iss_hit[r]) begin
                        busy_q[r] <= 1'b1;
                        tag_q[r]  <= bus.issue_tag;
                    end else if (clr_hit[r]) begin
                        busy_q[r] <= 1'b0;
                        tag_q[r]  <= '0;
                    end
                end
            end
        end
    end

    // Running population count of the busy bits.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            count_q <= '0;
        end else if (bus.rdy_in) begin
            if (bus.flush_pipline) begin
                count_q <= '0;
            end else begin
                count_q <= count_d;
            end
        end
    end

    // Full 32-entry read views with x0 hard-wired idle.
    always_comb begin
        busy_v   = {busy_q, 1'b0};
        tag_v[0] = '0;
        for (int r = 1; r < 32; r++) begin
            tag_v[r] = tag_q[r];
        end
    end

    assign bus.rs1_busy = busy_v[bus.rs1_reg_id];
    assign bus.rs2_busy = busy_v[bus.rs2_reg_id];
    assign bus.rs1_tag  = bus.rs1_busy ? tag_v[bus.rs1_reg_id] : '0;
    assign bus.rs2_tag  = bus.rs2_busy ? tag_v[bus.rs2_reg_id] : '0;
    assign bus.busy_count = count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed stimulus pushes expected query
// results into a queue; a monitor pops and compares them.
module tb_regfile_scoreboard;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;

    always #5 clk_in = ~clk_in;

    regfile_scoreboard_if #(.TAG_W(4)) bus ();

    regfile_scoreboard #(.TAG_W(4)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    typedef struct {
        string      name;
        logic       b1;
        logic [3:0] t1;
        logic       b2;
        logic [3:0] t2;
        logic [5:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    logic chk_valid = 1'b0;
    int   total  = 0;
    int   passed = 0;

    // Monitor: compare outputs mid-cycle whenever a check is presented.
    always @(negedge clk_in) begin
        if (chk_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL monitor: output presented with no expectation");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.rs1_busy === e.b1 && bus.rs1_tag === e.t1 &&
                    bus.rs2_busy === e.b2 && bus.rs2_tag === e.t2 &&
                    bus.busy_count === e.cnt) begin
                    passed++;
                end else begin
                    $display("FAIL %s: got b1=%0b t1=%0d b2=%0b t2=%0d cnt=%0d want b1=%0b t1=%0d b2=%0b t2=%0d cnt=%0d",
                             e.name, bus.rs1_busy, bus.rs1_tag,
                             bus.rs2_busy, bus.rs2_tag, bus.busy_count,
                             e.b1, e.t1, e.b2, e.t2, e.cnt);
                end
            end
        end
    end

    task automatic idle();
        rst_in            = 1'b1;
        bus.rdy_in        = 1'b1;
        bus.flush_pipline = 1'b0;
        bus.issue_valid   = 1'b0;
        bus.issue_rd      = '0;
        bus.issue_tag     = '0;
        bus.commit_valid  = 1'b0;
        bus.commit_rd     = '0;
        bus.commit_tag    = '0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        chk_valid = 1'b0;
        idle();
    endtask

    task automatic issue(input logic [4:0] rd, input logic [3:0] tag);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = rd;
        bus.issue_tag   = tag;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [3:0] tag);
        bus.commit_valid = 1'b1;
        bus.commit_rd    = rd;
        bus.commit_tag   = tag;
    endtask

    task automatic expect_q(input string name,
                            input logic [4:0] id1, input logic [4:0] id2,
                            input logic b1, input logic [3:0] t1,
                            input logic b2, input logic [3:0] t2,
                            input logic [5:0] cnt);
        exp_t e;
        e.name = name;
        e.b1 = b1; e.t1 = t1; e.b2 = b2; e.t2 = t2; e.cnt = cnt;
        bus.rs1_reg_id = id1;
        bus.rs2_reg_id = id2;
        exp_q.push_back(e);
        chk_valid = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        idle();
        rst_in = 1'b0;
        bus.rs1_reg_id = '0;
        bus.rs2_reg_id = '0;
        tick();

        expect_q("reset_state", 5'd0, 5'd7, 0, 0, 0, 0, 0);
        tick();

        issue(5, 3);
        expect_q("same_cycle_no_bypass", 5'd5, 5'd0, 0, 0, 0, 0, 0);
        tick();
        expect_q("issue_x5_t3", 5'd5, 5'd0, 1, 3, 0, 0, 1);
        tick();

        issue(5, 7);
        expect_q("pre_reissue_x5", 5'd5, 5'd0, 1, 3, 0, 0, 1);
        tick();
        commit(5, 3);
        expect_q("reissue_x5_t7", 5'd5, 5'd0, 1, 7, 0, 0, 1);
        tick();
        commit(5, 7);
        expect_q("stale_commit_ignored", 5'd5, 5'd0, 1, 7, 0, 0, 1);
        tick();
        expect_q("commit_x5_t7", 5'd5, 5'd0, 0, 0, 0, 0, 0);
        tick();

        issue(8, 2);
        tick();
        issue(8, 9);
        commit(8, 2);
        expect_q("x8_busy_t2", 5'd8, 5'd0, 1, 2, 0, 0, 1);
        tick();
        expect_q("issue_beats_commit", 5'd8, 5'd0, 1, 9, 0, 0, 1);
        tick();

        issue(3, 4);
        commit(8, 9);
        tick();
        expect_q("independent_regs", 5'd3, 5'd8, 1, 4, 0, 0, 1);
        tick();
        commit(3, 4);
        tick();
        expect_q("commit_x3", 5'd3, 5'd8, 0, 0, 0, 0, 0);
        tick();

        issue(0, 1);
        commit(0, 1);
        tick();
        expect_q("x0_ignored", 5'd0, 5'd0, 0, 0, 0, 0, 0);
        tick();

        commit(9, 0);
        tick();
        expect_q("commit_idle_no_underflow", 5'd9, 5'd0, 0, 0, 0, 0, 0);
        tick();

        for (int r = 1; r < 32; r++) begin
            issue(5'(r), 4'(r));
            if (r == 16)
                expect_q("fill_midway", 5'd15, 5'd16, 1, 15, 0, 0, 15);
            tick();
        end
        issue(4, 5);
        bus.flush_pipline = 1'b1;
        expect_q("all_busy", 5'd31, 5'd16, 1, 15, 1, 0, 31);
        tick();
        expect_q("flush_clears", 5'd31, 5'd4, 0, 0, 0, 0, 0);
        tick();

        issue(10, 6);
        tick();
        bus.rdy_in = 1'b0;
        issue(11, 2);
        commit(10, 6);
        bus.flush_pipline = 1'b1;
        expect_q("stall_pre", 5'd10, 5'd11, 1, 6, 0, 0, 1);
        tick();
        expect_q("stall_held", 5'd10, 5'd11, 1, 6, 0, 0, 1);
        tick();
        rst_in = 1'b0;
        issue(12, 3);
        tick();
        expect_q("reset_clears", 5'd10, 5'd12, 0, 0, 0, 0, 0);
        tick();

        issue(20, 1);
        tick();
        rst_in = 1'b0;
        bus.rdy_in = 1'b0;
        issue(21, 2);
        tick();
        expect_q("reset_beats_stall", 5'd20, 5'd21, 0, 0, 0, 0, 0);
        tick();

        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(negedge clk_in);
            guard++;
        end
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
